alu_rr_scheduler: RTL and testbench

- Shares one WIDTH-bit signed ALU datapath (add, sub, bitwise and, bitwise xor) between two requesters.
- Arbitration is round-robin. Each accepted operation is sequenced through a registered operand stage and a registered result stage.
- Every result returns on a single valid/ready result port, tagged with the requester id.
- Sits between the two instruction-issue front ends and the ALU result writeback.

---
 rtl/alu_rr_scheduler_if.sv | 40 ++++
 rtl/alu_rr_scheduler.sv | 140 ++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rr_scheduler_if.sv
// Request/result bundle for the shared-ALU scheduler: two issue front ends in,
// one tagged result stream out.
interface alu_rr_scheduler_if #(
   parameter int WIDTH = 64
);
   logic                    req0_valid;
   logic                    req0_ready;
   logic [1:0]              req0_op;
   logic signed [WIDTH-1:0] req0_a;
   logic signed [WIDTH-1:0] req0_b;

   logic                    req1_valid;
   logic                    req1_ready;
   logic [1:0]              req1_op;
   logic signed [WIDTH-1:0] req1_a;
   logic signed [WIDTH-1:0] req1_b;

   logic                    res_valid;
   logic                    res_ready;
   logic                    res_id;
   logic signed [WIDTH-1:0] res_data;
   logic                    res_zero;
   logic                    res_ovf;

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output res_ready,
      input  req0_ready, req1_ready,
      input  res_valid, res_id, res_data, res_zero, res_ovf
   );

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  res_ready,
      output req0_ready, req1_ready,
      output res_valid, res_id, res_data, res_zero, res_ovf
   );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one signed add/sub/and/xor datapath between two
// requesters; each operation runs IDLE (grant) -> EXEC (compute) -> HOLD (result).
module alu_rr_scheduler #(
   parameter int WIDTH = 64
) (
   input logic               clk,
   input logic               rst,
   alu_rr_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t                  state;
   logic                    last_grant;

   logic [1:0]              op_p0;
   logic signed [WIDTH-1:0] a_p0;
   logic signed [WIDTH-1:0] b_p0;
   logic                    id_p0;
   logic signed [WIDTH-1:0] alu_r_p0;
   logic                    alu_ovf_p0;

   logic                    vld_p1;
   logic                    id_p1;
   logic signed [WIDTH-1:0] data_p1;
   logic                    zero_p1;
   logic                    ovf_p1;

   logic                    in_idle;
   logic                    grant0;
   logic                    grant1;
   logic                    hs0;
   logic                    hs1;

   function automatic logic signed [WIDTH-1:0] alu_calc(
      input logic [1:0]              op,
      input logic signed [WIDTH-1:0] a,
      input logic signed [WIDTH-1:0] b
   );
      case (op)
         2'b00:   alu_calc = a + b;
         2'b01:   alu_calc = a - b;
         2'b10:   alu_calc = a & b;
         default: alu_calc = a ^ b;
      endcase
   endfunction

   // Wrapping add/sub overflows when the result sign breaks from a's sign
   // although the operand signs made that impossible.
   function automatic logic alu_ovf(
      input logic [1:0]              op,
      input logic signed [WIDTH-1:0] a,
      input logic signed [WIDTH-1:0] b,
      input logic signed [WIDTH-1:0] r
   );
      logic sa;
      logic sb;
      logic sr;
      sa = a[WIDTH-1];
      sb = b[WIDTH-1];
      sr = r[WIDTH-1];
      case (op)
         2'b00:   alu_ovf = (sa == sb) && (sr != sa);
         2'b01:   alu_ovf = (sa != sb) && (sr != sa);
         default: alu_ovf = 1'b0;
      endcase
   endfunction

   // A tie goes to whichever requester was not served last.
   assign in_idle = (state == IDLE) && !rst;
   assign grant0  = bus.req0_valid && (!bus.req1_valid || last_grant);
   assign grant1  = bus.req1_valid && (!bus.req0_valid || !last_grant);

   assign bus.req0_ready = in_idle && grant0;
   assign bus.req1_ready = in_idle && grant1;

   assign hs0 = bus.req0_valid && bus.req0_ready;
   assign hs1 = bus.req1_valid && bus.req1_ready;

   // Stage p0: operand capture on handshake
   always_ff @(posedge clk) begin
      if (hs0 || hs1) begin
         op_p0 <= hs1 ? bus.req1_op : bus.req0_op;
         a_p0  <= hs1 ? bus.req1_a  : bus.req0_a;
         b_p0  <= hs1 ? bus.req1_b  : bus.req0_b;
         id_p0 <= hs1;
      end
   end

   assign alu_r_p0   = alu_calc(op_p0, a_p0, b_p0);
   assign alu_ovf_p0 = alu_ovf(op_p0, a_p0, b_p0, alu_r_p0);

   // Stage p1: result registers, owned by the sequencing FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         vld_p1     <= 1'b0;
         id_p1      <= 1'b0;
         data_p1    <= '0;
         zero_p1    <= 1'b0;
         ovf_p1     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (hs0 || hs1) begin
                  last_grant <= hs1;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               data_p1 <= alu_r_p0;
               zero_p1 <= (alu_r_p0 == '0);
               ovf_p1  <= alu_ovf_p0;
               id_p1   <= id_p0;
               vld_p1  <= 1'b1;
               state   <= HOLD;
            end
            HOLD: begin
               if (bus.res_ready) begin
                  vld_p1 <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.res_valid = vld_p1;
   assign bus.res_id    = id_p1;
   assign bus.res_data  = data_p1;
   assign bus.res_zero  = zero_p1;
   assign bus.res_ovf   = ovf_p1;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler: a scoreboard queue is filled on each
// observed request handshake and drained on each result transfer.
module tb_alu_rr_scheduler;
   localparam int WIDTH = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_rr_scheduler_if #(.WIDTH(WIDTH)) bus ();
   alu_rr_scheduler #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic             id;
      logic [WIDTH-1:0] data;
      logic             zero;
      logic             ovf;
      int               cyc;
   } exp_t;

   exp_t sbq[$];
   int   pop_cyc[$];
   logic pop_id[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic prev_valid = 1'b0;
   logic prev_ready = 1'b0;
   logic [1:0] hs_seen = 2'b00;

   function automatic exp_t model(input logic id, input logic [1:0] op,
                                  input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input int c);
      exp_t e;
      logic signed [WIDTH:0] w;
      e.id = id; e.cyc = c; e.ovf = 1'b0; w = '0;
      case (op)
         2'b00: begin
            w = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
            e.data = w[WIDTH-1:0]; e.ovf = (w[WIDTH] != w[WIDTH-1]);
         end
         2'b01: begin
            w = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
            e.data = w[WIDTH-1:0]; e.ovf = (w[WIDTH] != w[WIDTH-1]);
         end
         2'b10:   e.data = a & b;
         default: e.data = a ^ b;
      endcase
      e.zero = (e.data == '0);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic sample();
      exp_t e;
      hs_seen = 2'b00;
      chk("one_ready", WIDTH'(bus.req0_ready && bus.req1_ready), 64'd0);
      if (bus.req0_valid && bus.req0_ready) begin
         sbq.push_back(model(1'b0, bus.req0_op, bus.req0_a, bus.req0_b, cyc));
         hs_seen[0] = 1'b1;
      end
      if (bus.req1_valid && bus.req1_ready) begin
         sbq.push_back(model(1'b1, bus.req1_op, bus.req1_a, bus.req1_b, cyc));
         hs_seen[1] = 1'b1;
      end
      if (bus.res_valid) begin
         if (sbq.size() == 0) begin
            chk("spurious_res_valid", WIDTH'(bus.res_valid), 64'd0);
         end else begin
            e = sbq[0];
            if (!prev_valid) chk("latency", WIDTH'(cyc - e.cyc), 64'd2);
            if (prev_valid && !prev_ready) begin
               chk("hold_data", bus.res_data, e.data);
               chk("hold_id", WIDTH'(bus.res_id), WIDTH'(e.id));
               chk("hold_no_ready", WIDTH'(bus.req0_ready || bus.req1_ready), 64'd0);
            end
            if (bus.res_ready) begin
               void'(sbq.pop_front());
               chk("res_id", WIDTH'(bus.res_id), WIDTH'(e.id));
               chk("res_data", bus.res_data, e.data);
               chk("res_zero", WIDTH'(bus.res_zero), WIDTH'(e.zero));
               chk("res_ovf", WIDTH'(bus.res_ovf), WIDTH'(e.ovf));
               pop_cyc.push_back(cyc);
               pop_id.push_back(bus.res_id);
            end
         end
      end
      prev_valid = bus.res_valid;
      prev_ready = bus.res_ready;
   endtask

   task automatic step();
      @(negedge clk);
      sample();
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic id, input logic [1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input bit immediate);
      int n;
      n = 0;
      if (!id) begin
         bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
      end else begin
         bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
      end
      #1;
      if (immediate) chk("ready_now", WIDTH'(id ? bus.req1_ready : bus.req0_ready), 64'd1);
      do begin
         step();
         n++;
      end while (!hs_seen[id] && n < 20);
      chk("issue_accepted", WIDTH'(hs_seen[id]), 64'd1);
      if (!id) bus.req0_valid = 1'b0;
      else     bus.req1_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n;
      n = 0;
      while ((sbq.size() != 0 || bus.res_valid) && n < max) begin
         step();
         n++;
      end
      chk("drain", WIDTH'(sbq.size() == 0 && !bus.res_valid), 64'd1);
   endtask

   initial begin
      int n_hs;
      int guard;
      rst = 1'b1;
      bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_a = '0; bus.req0_b = '0;
      bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_a = '0; bus.req1_b = '0;
      bus.res_ready  = 1'b1;
      repeat (2) step();
      chk("rst_res_valid", WIDTH'(bus.res_valid), 64'd0);
      chk("rst_res_id", WIDTH'(bus.res_id), 64'd0);
      chk("rst_res_data", bus.res_data, 64'd0);
      chk("rst_res_zero", WIDTH'(bus.res_zero), 64'd0);
      chk("rst_res_ovf", WIDTH'(bus.res_ovf), 64'd0);
      bus.req0_valid = 1'b1;
      #1;
      chk("rst_no_ready", WIDTH'(bus.req0_ready || bus.req1_ready), 64'd0);
      bus.req0_valid = 1'b0;
      rst = 1'b0;
      step();

      issue(1'b0, 2'b00, 64'd5, 64'd3, 1'b1);
      wait_idle(10);
      issue(1'b1, 2'b10, 64'h405, 64'h403, 1'b1);
      wait_idle(10);
      issue(1'b1, 2'b11, 64'h5D9F, 64'h5D9F, 1'b1);
      wait_idle(10);

      // Both requesters held valid: grants must alternate starting with req0.
      pop_id.delete(); pop_cyc.delete();
      bus.req0_valid = 1'b1; bus.req0_op = 2'($urandom_range(0, 3));
      bus.req0_a = {$urandom, $urandom}; bus.req0_b = {$urandom, $urandom};
      bus.req1_valid = 1'b1; bus.req1_op = 2'($urandom_range(0, 3));
      bus.req1_a = {$urandom, $urandom}; bus.req1_b = {$urandom, $urandom};
      n_hs = 0; guard = 0;
      while (n_hs < 4 && guard < 40) begin
         step();
         guard++;
         if (hs_seen[0]) begin
            n_hs++;
            bus.req0_op = 2'($urandom_range(0, 3));
            bus.req0_a = {$urandom, $urandom}; bus.req0_b = {$urandom, $urandom};
         end
         if (hs_seen[1]) begin
            n_hs++;
            bus.req1_op = 2'($urandom_range(0, 3));
            bus.req1_a = {$urandom, $urandom}; bus.req1_b = {$urandom, $urandom};
         end
      end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      wait_idle(20);
      chk("rr_count", WIDTH'(pop_id.size()), 64'd4);
      for (int i = 0; i < 4 && i < pop_id.size(); i++)
         chk($sformatf("rr_id_%0d", i), WIDTH'(pop_id[i]), WIDTH'(i % 2));
      for (int i = 1; i < 4 && i < pop_cyc.size(); i++)
         chk($sformatf("rr_gap_%0d", i), WIDTH'(pop_cyc[i] - pop_cyc[i-1]), 64'd3);

      issue(1'b0, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
      wait_idle(10);
      issue(1'b0, 2'b01, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
      wait_idle(10);

      // Stalled consumer with a second request waiting behind the held result.
      bus.res_ready = 1'b0;
      issue(1'b0, 2'b00, 64'h1234, 64'h4321, 1'b1);
      bus.req1_valid = 1'b1; bus.req1_op = 2'b01;
      bus.req1_a = 64'hFFFF_FFFF_FFFF_FFF0; bus.req1_b = 64'd7;
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_valid", WIDTH'(bus.res_valid), 64'd1);
         chk("stall_data", bus.res_data, 64'h5555);
         chk("stall_req1_ready", WIDTH'(bus.req1_ready), 64'd0);
      end
      bus.res_ready = 1'b1;
      step();
      chk("release_valid_drop", WIDTH'(bus.res_valid), 64'd0);
      chk("release_grant_pending", WIDTH'(bus.req1_ready), 64'd1);
      step();
      chk("pending_accepted", WIDTH'(hs_seen[1]), 64'd1);
      bus.req1_valid = 1'b0;
      wait_idle(10);

      // Reset during EXEC aborts the operation and restores last_grant.
      issue(1'b0, 2'b01, 64'd10, 64'd4, 1'b1);
      rst = 1'b1;
      step();
      sbq.delete();
      rst = 1'b0;
      chk("abort_res_valid", WIDTH'(bus.res_valid), 64'd0);
      chk("abort_res_data", bus.res_data, 64'd0);
      chk("abort_res_id", WIDTH'(bus.res_id), 64'd0);
      chk("abort_res_zero", WIDTH'(bus.res_zero), 64'd0);
      chk("abort_res_ovf", WIDTH'(bus.res_ovf), 64'd0);
      repeat (4) step();
      chk("abort_no_result", WIDTH'(bus.res_valid), 64'd0);
      bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_a = 64'd7; bus.req0_b = 64'd8;
      bus.req1_valid = 1'b1; bus.req1_op = 2'b11; bus.req1_a = 64'hF0; bus.req1_b = 64'h0F;
      guard = 0;
      do begin
         step();
         guard++;
      end while (hs_seen == 2'b00 && guard < 10);
      chk("tie_after_reset", WIDTH'(hs_seen), 64'd1);
      bus.req0_valid = 1'b0;
      guard = 0;
      while (!hs_seen[1] && guard < 20) begin
         step();
         guard++;
      end
      chk("tie_second", WIDTH'(hs_seen[1]), 64'd1);
      bus.req1_valid = 1'b0;
      wait_idle(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
